regfile_wb_scheduler: RTL

Write-back scheduler for the 16x16 register file's two write ports (`RegWrite`, `WriteOP2`, `WriteReg1/2`, `WriteData1/2`). It merges single-result pipeline write-backs with two-result multiply/divide (MDU) write-backs (low/quotient to a destination register, high/remainder to R15). MDU results sit in a one-entry buffer and drain into spare write-port slots. A pending-register mask tells the hazard unit which registers are stale.

---
 rtl/regfile_wb_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_scheduler.sv
// ----------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Schedules the two write ports of the 16x16 register file. Pipeline
// write-backs pass straight through on port 1 and are never stalled. Results
// from the multiply/divide unit (MDU) can carry two values: lo/quotient goes to
// md_reg_i and hi/remainder goes to R15. They are held in a one-entry buffer
// and drained into whichever write-port slots the pipeline leaves free.
//
// Ports
//   clk_i            rising-edge clock, shared with the register file
//   rst_ni           asynchronous active-low reset
//   wb_valid_i       pipeline write-back this cycle
//   wb_reg_i         pipeline destination register
//   wb_data_i        pipeline result
//   md_valid_i       MDU result offered (held stable until accepted)
//   md_ready_o       buffer empty, so an MDU result can be accepted
//   md_reg_i         destination register for md_lo_i
//   md_lo_i          low product / quotient
//   md_hi_i          high product / remainder, always written to R15
//   md_pair_i        1: write lo and hi, 0: write lo only
//   rf_reg_write_o   RegWrite
//   rf_write_op2_o   WriteOP2
//   rf_write_reg1_o  WriteReg1
//   rf_write_reg2_o  WriteReg2
//   rf_write_data1_o WriteData1
//   rf_write_data2_o WriteData2
//   pending_mask_o   bit i set: a buffered MDU write to register i is still
//                    uncommitted
// ----------------------------------------------------------------------------
module regfile_wb_scheduler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_valid_i,
    input  logic [3:0]  wb_reg_i,
    input  logic [15:0] wb_data_i,
    input  logic        md_valid_i,
    output logic        md_ready_o,
    input  logic [3:0]  md_reg_i,
    input  logic [15:0] md_lo_i,
    input  logic [15:0] md_hi_i,
    input  logic        md_pair_i,
    output logic        rf_reg_write_o,
    output logic        rf_write_op2_o,
    output logic [3:0]  rf_write_reg1_o,
    output logic [3:0]  rf_write_reg2_o,
    output logic [15:0] rf_write_data1_o,
    output logic [15:0] rf_write_data2_o,
    output logic [15:0] pending_mask_o
);

    localparam logic [3:0] HI_REG = 4'd15;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        lo_pend_q, lo_pend_d;
    logic        hi_pend_q, hi_pend_d;
    logic [3:0]  b_reg_q, b_reg_d;
    logic [15:0] b_lo_q, b_lo_d;
    logic [15:0] b_hi_q, b_hi_d;
    logic [15:0] pending_mask_q, pending_mask_d;

    logic        we_c, op2_c;
    logic [3:0]  reg1_c, reg2_c;
    logic [15:0] data1_c, data2_c;
    logic        capture;
    logic        lo_live, hi_live;

    // Control state: cleared by reset, which also drops any buffered write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= EMPTY;
            lo_pend_q      <= 1'b0;
            hi_pend_q      <= 1'b0;
            pending_mask_q <= '0;
        end else begin
            state_q        <= state_d;
            lo_pend_q      <= lo_pend_d;
            hi_pend_q      <= hi_pend_d;
            pending_mask_q <= pending_mask_d;
        end
    end

    // Buffer payload is only meaningful while a pend flag is set.
    always_ff @(posedge clk_i) begin
        b_reg_q <= b_reg_d;
        b_lo_q  <= b_lo_d;
        b_hi_q  <= b_hi_d;
    end

    assign capture = rst_ni && (state_q == EMPTY) && md_valid_i;
    // A pending write whose target the pipeline writes this cycle is stale.
    assign lo_live = lo_pend_q && (b_reg_q != wb_reg_i);
    assign hi_live = hi_pend_q && (wb_reg_i != HI_REG);

    always_comb begin
        lo_pend_d = lo_pend_q;
        hi_pend_d = hi_pend_q;
        b_reg_d   = b_reg_q;
        b_lo_d    = b_lo_q;
        b_hi_d    = b_hi_q;
        we_c      = wb_valid_i;
        op2_c     = 1'b0;
        reg1_c    = wb_reg_i;
        data1_c   = wb_data_i;
        reg2_c    = '0;
        data2_c   = '0;

        if (state_q == FULL) begin
            if (!wb_valid_i) begin
                // Both ports are free: everything pending retires now.
                we_c      = lo_pend_q || hi_pend_q;
                lo_pend_d = 1'b0;
                hi_pend_d = 1'b0;
                if (lo_pend_q) begin
                    reg1_c  = b_reg_q;
                    data1_c = b_lo_q;
                    if (hi_pend_q) begin
                        op2_c   = 1'b1;
                        reg2_c  = HI_REG;
                        data2_c = b_hi_q;
                    end
                end else begin
                    reg1_c  = HI_REG;
                    data1_c = b_hi_q;
                end
            end else begin
                // Port 1 belongs to the pipeline; one survivor uses port 2,
                // lo before hi. Superseded writes are simply dropped.
                lo_pend_d = 1'b0;
                hi_pend_d = 1'b0;
                if (lo_live) begin
                    op2_c     = 1'b1;
                    reg2_c    = b_reg_q;
                    data2_c   = b_lo_q;
                    hi_pend_d = hi_live;
                end else if (hi_live) begin
                    op2_c   = 1'b1;
                    reg2_c  = HI_REG;
                    data2_c = b_hi_q;
                end
            end
        end else if (capture) begin
            b_reg_d   = md_reg_i;
            b_lo_d    = md_lo_i;
            b_hi_d    = md_hi_i;
            hi_pend_d = md_pair_i;
            // hi also targets R15, and the later write wins.
            lo_pend_d = !(md_pair_i && (md_reg_i == HI_REG));
        end

        state_d = (lo_pend_d || hi_pend_d) ? FULL : EMPTY;

        pending_mask_d = '0;
        if (lo_pend_d) pending_mask_d[b_reg_d] = 1'b1;
        if (hi_pend_d) pending_mask_d[HI_REG]  = 1'b1;
    end

    // Register-file controls are silenced while reset is held.
    always_comb begin
        rf_reg_write_o   = we_c && rst_ni;
        rf_write_op2_o   = op2_c && rst_ni;
        rf_write_reg1_o  = rst_ni ? reg1_c  : '0;
        rf_write_reg2_o  = rst_ni ? reg2_c  : '0;
        rf_write_data1_o = rst_ni ? data1_c : '0;
        rf_write_data2_o = rst_ni ? data2_c : '0;
        md_ready_o       = rst_ni && (state_q == EMPTY);
    end

    assign pending_mask_o = pending_mask_q;

endmodule
